// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART write front end.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS = 8;

  // Width of a counter that must hold values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_wr_sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned         WIDTH   = 1,
  parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_wr.sv
// UART receiver turning each good 8N1 frame (8E1 with UART_RX_PARITY_EN) into a
// one-cycle write strobe plus data byte for the GPIO register.
module uart_rx_wr
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [CW-1:0]        cyc_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_ok;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign par_ok = ~par_err;
`else
  assign par_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (!ena) begin
        state   <= IDLE;
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            if (!rx_s) state <= START;
          end
          // Mid-bit check of the start bit; a high sample is treated as a glitch.
          START: begin
            if (cyc_cnt == HALF_LAST) begin
              cyc_cnt <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          DATA: begin
            if (cyc_cnt == BIT_LAST) begin
              cyc_cnt <= '0;
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cyc_cnt == BIT_LAST) begin
              cyc_cnt <= '0;
              par_err <= rx_s ^ (^shift);
              state   <= STOP;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
`endif
          // Returning to IDLE at mid-stop lets a following start bit be caught with no gap.
          STOP: begin
            if (cyc_cnt == BIT_LAST) begin
              cyc_cnt <= '0;
              state   <= IDLE;
              if (rx_s && par_ok) begin
                wr_data <= shift;
                wr_en   <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_wr.sv
// Directed self-checking bench for uart_rx_wr at 8 clocks per bit.
module tb_uart_rx_wr;

  localparam int unsigned N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       rx  = 1'b1;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wr_q[$];
  int n_wr      = 0;
  int n_err     = 0;
  int n_both    = 0;
  bit busy_seen = 1'b0;

  uart_rx_wr #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rx        (rx),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back(wr_data);
      n_wr++;
    end
    if (frame_err) n_err++;
    if (wr_en && frame_err) n_both++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic clear_mon();
    @(posedge clk);
    wr_q.delete();
    n_wr = 0;
    n_err = 0;
    n_both = 0;
    busy_seen = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (N) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b) rx = 1'b1;
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] a5;
    a5 = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, frame_err, busy, wr_data} !== 11'h000) begin
      failures++;
      $display("FAIL reset_state: got wr_en=%0b frame_err=%0b busy=%0b wr_data=%h expected all 0",
               wr_en, frame_err, busy, wr_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(a5[i]);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_midframe_busy: got %0b expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, frame_err, busy, wr_data} !== 11'h000) begin
      failures++;
      $display("FAIL reset_async: got wr_en=%0b frame_err=%0b busy=%0b wr_data=%h expected all 0",
               wr_en, frame_err, busy, wr_data);
    end
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    settle(4);
    checks++;
    if (n_wr !== 1 || n_err !== 0) begin
      failures++;
      $display("FAIL reset_frame_pulses: got wr_cycles=%0d err_cycles=%0d expected 1 and 0", n_wr, n_err);
    end
    checks++;
    if (wr_q.size() < 1 || wr_q[0] !== 8'hA5) begin
      failures++;
      $display("FAIL reset_frame_data: got %h expected a5", (wr_q.size() > 0) ? wr_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    exp_b = '{8'h00, 8'hFF, 8'h3C};
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0);
    settle(6);
    checks++;
    if (n_wr !== 3 || n_err !== 0 || n_both !== 0) begin
      failures++;
      $display("FAIL b2b_counts: got wr_cycles=%0d err_cycles=%0d both=%0d expected 3 0 0",
               n_wr, n_err, n_both);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_q.size() <= i || wr_q[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %h expected %h", i,
                 (wr_q.size() > i) ? wr_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_bad_stop();
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b0);
    settle(20);
    checks++;
    if (n_err !== 1 || n_wr !== 0) begin
      failures++;
      $display("FAIL badstop_pulses: got err_cycles=%0d wr_cycles=%0d expected 1 and 0", n_err, n_wr);
    end
    checks++;
    if (wr_data !== 8'h3C) begin
      failures++;
      $display("FAIL badstop_hold: got wr_data=%h expected 3c", wr_data);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    settle(20);
    checks++;
    if (busy_seen !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_rise: got busy_seen=%0b expected 1", busy_seen);
    end
    checks++;
    if (busy !== 1'b0 || n_wr !== 0 || n_err !== 0) begin
      failures++;
      $display("FAIL glitch_reject: got busy=%0b wr_cycles=%0d err_cycles=%0d expected 0 0 0",
               busy, n_wr, n_err);
    end
  endtask

  task automatic test_enable_abort();
    logic [7:0] d;
    d = 8'h81;
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (4) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%0b expected 0", busy);
    end
    repeat (N - 5) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    repeat (4) @(negedge clk);
    ena = 1'b1;
    settle(4);
    checks++;
    if (n_wr !== 0 || n_err !== 0) begin
      failures++;
      $display("FAIL abort_no_pulse: got wr_cycles=%0d err_cycles=%0d expected 0 0", n_wr, n_err);
    end
    clear_mon();
    send_frame(8'h81, 1'b1, 1'b0);
    settle(4);
    checks++;
    if (n_wr !== 1 || n_err !== 0 || wr_data !== 8'h81) begin
      failures++;
      $display("FAIL abort_recover: got wr_cycles=%0d err_cycles=%0d wr_data=%h expected 1 0 81",
               n_wr, n_err, wr_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    settle(4);
    checks++;
    if (n_wr !== 1 || n_err !== 0 || wr_data !== 8'h07) begin
      failures++;
      $display("FAIL parity_good: got wr_cycles=%0d err_cycles=%0d wr_data=%h expected 1 0 07",
               n_wr, n_err, wr_data);
    end
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    settle(4);
    checks++;
    if (n_wr !== 0 || n_err !== 1) begin
      failures++;
      $display("FAIL parity_bad: got wr_cycles=%0d err_cycles=%0d expected 0 1", n_wr, n_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_bad_stop();
    test_glitch();
    test_enable_abort();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
